// File: rtl/mem_port_arbiter_if.sv
// Fetch/data requester ports and the shared single-port memory bus.
// The arbiter takes the slave side; requesters and memory sit on the master side.
interface mem_port_arbiter_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_ack;
    logic [31:0] if_rdata;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_ack;
    logic [31:0] d_rdata;
    logic [11:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_re;
    logic        mem_we;
    logic [31:0] mem_rdata;
    logic        stall_if;
    logic        stall_mem;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        output if_ack, if_rdata, d_ack, d_rdata, mem_addr, mem_wdata,
        output mem_re, mem_we, stall_if, stall_mem
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        input  if_ack, if_rdata, d_ack, d_rdata, mem_addr, mem_wdata,
        input  mem_re, mem_we, stall_if, stall_mem
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch and data accesses onto one shared memory port.
// Data has priority; fetch wins after STARVE_MAX consecutive losses.
module mem_port_arbiter #(
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 4
) (
    input logic               Clk,
    input logic               Rst,
    mem_port_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, IACC, DACC} state_t;

    state_t      state_q, state_d;
    logic [2:0]  lat_q;
    logic [3:0]  starve_q;
    logic [11:0] addr_q;
    logic [31:0] wdata_q;
    logic        we_q;
    logic        if_ack_q, d_ack_q;
    logic [31:0] if_rdata_q, d_rdata_q;

    logic if_pend, d_pend, hold, fetch_wins, last, gnt_i, gnt_d;
    logic unused_addr_hi;

    assign unused_addr_hi = ^{bus.if_addr[31:12], bus.d_addr[31:12]};

    // A requester just acked is not eligible this cycle.
    assign if_pend    = bus.if_req & ~if_ack_q;
    assign d_pend     = bus.d_req  & ~d_ack_q;
    // If the acked requester is still asking, nobody is granted this cycle so it
    // competes again next cycle and the starvation count stays meaningful.
    assign hold       = (if_ack_q & bus.if_req) | (d_ack_q & bus.d_req);
    assign fetch_wins = if_pend & (~d_pend | (starve_q == 4'(STARVE_MAX)));
    assign last       = (lat_q == 3'd0);
    assign gnt_i      = (state_q == IDLE) && (state_d == IACC);
    assign gnt_d      = (state_q == IDLE) && (state_d == DACC);

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (!hold) begin
                    if (fetch_wins)  state_d = IACC;
                    else if (d_pend) state_d = DACC;
                end
            end
            IACC, DACC: if (last) state_d = IDLE;
            default:    state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.mem_re = 1'b0;
        bus.mem_we = 1'b0;
        case (state_q)
            IACC:    bus.mem_re = 1'b1;
            DACC: begin
                bus.mem_re = ~we_q;
                bus.mem_we = we_q & last;
            end
            default: ;
        endcase
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            lat_q      <= 3'd0;
            starve_q   <= 4'd0;
            addr_q     <= 12'h0;
            wdata_q    <= 32'h0;
            we_q       <= 1'b0;
            if_ack_q   <= 1'b0;
            d_ack_q    <= 1'b0;
            if_rdata_q <= 32'h0;
            d_rdata_q  <= 32'h0;
        end else begin
            if_ack_q <= (state_q == IACC) && last;
            d_ack_q  <= (state_q == DACC) && last;
            if (gnt_i || gnt_d) lat_q <= 3'(MEM_LAT - 1);
            else if (state_q != IDLE && !last) lat_q <= lat_q - 3'd1;

            if (gnt_i) begin
                starve_q <= 4'd0;
                addr_q   <= bus.if_addr[11:0];
                we_q     <= 1'b0;
            end else if (gnt_d) begin
                if (if_pend) starve_q <= starve_q + 4'd1;
                addr_q  <= bus.d_addr[11:0];
                we_q    <= bus.d_we;
                wdata_q <= bus.d_wdata;
            end

            if (state_q == IACC && last)          if_rdata_q <= bus.mem_rdata;
            if (state_q == DACC && last && !we_q) d_rdata_q  <= bus.mem_rdata;
        end
    end

    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.if_ack    = if_ack_q;
    assign bus.d_ack     = d_ack_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.stall_if  = bus.if_req & ~if_ack_q;
    assign bus.stall_mem = bus.d_req  & ~d_ack_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: default arbiter (MEM_LAT=2, STARVE_MAX=4) and a MEM_LAT=1 copy.
module tb_mem_port_arbiter;
    logic Clk = 1'b0;
    logic Rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 Clk = ~Clk;

    mem_port_arbiter_if bus ();
    mem_port_arbiter_if bus1 ();

    mem_port_arbiter #(.MEM_LAT(2), .STARVE_MAX(4)) dut  (.Clk(Clk), .Rst(Rst), .bus(bus));
    mem_port_arbiter #(.MEM_LAT(1), .STARVE_MAX(4)) dut1 (.Clk(Clk), .Rst(Rst), .bus(bus1));

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.if_req = 0; bus.if_addr = 0; bus.d_req = 0; bus.d_we = 0;
        bus.d_addr = 0; bus.d_wdata = 0; bus.mem_rdata = 0;
        bus1.if_req = 0; bus1.if_addr = 0; bus1.d_req = 0; bus1.d_we = 0;
        bus1.d_addr = 0; bus1.d_wdata = 0; bus1.mem_rdata = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        bus.if_req = 1; bus.d_req = 1; bus.d_we = 1; bus.mem_rdata = 32'hFFFF_FFFF;
        #1 Rst = 1;
        #1;
        checks++;
        if ({bus.if_ack, bus.d_ack, bus.mem_re, bus.mem_we} !== 4'b0) begin
            errors++; $display("FAIL reset_ctrl: got %b want 0000", {bus.if_ack, bus.d_ack, bus.mem_re, bus.mem_we});
        end
        checks++;
        if ({bus.if_rdata, bus.d_rdata, bus.mem_wdata, bus.mem_addr} !== 108'h0) begin
            errors++; $display("FAIL reset_data: got %h want 0", {bus.if_rdata, bus.d_rdata, bus.mem_wdata, bus.mem_addr});
        end
        step(); step();
        checks++;
        if (dut.starve_q !== 4'd0 || bus.mem_re !== 1'b0) begin
            errors++; $display("FAIL reset_hold: starve %0d mem_re %b want 0 0", dut.starve_q, bus.mem_re);
        end
        idle_inputs();
        Rst = 0;
        step();
    endtask

    task automatic test_fetch();
        bus.if_req = 1; bus.if_addr = 32'h10; bus.mem_rdata = 32'hDEADBEEF;
        #1;
        checks++;
        if (bus.stall_if !== 1'b1 || bus.mem_re !== 1'b0) begin
            errors++; $display("FAIL fetch_pre: stall_if %b mem_re %b want 1 0", bus.stall_if, bus.mem_re);
        end
        step();
        checks++;
        if (bus.mem_re !== 1'b1 || bus.mem_addr !== 12'h010 || bus.if_ack !== 1'b0) begin
            errors++; $display("FAIL fetch_c1: re %b addr %h ack %b want 1 010 0", bus.mem_re, bus.mem_addr, bus.if_ack);
        end
        step();
        checks++;
        if (bus.mem_re !== 1'b1 || bus.if_ack !== 1'b0) begin
            errors++; $display("FAIL fetch_c2: re %b ack %b want 1 0", bus.mem_re, bus.if_ack);
        end
        step();
        checks++;
        if (bus.if_ack !== 1'b1 || bus.if_rdata !== 32'hDEADBEEF || bus.mem_re !== 1'b0 || bus.stall_if !== 1'b0) begin
            errors++; $display("FAIL fetch_ack: ack %b rdata %h re %b stall %b want 1 deadbeef 0 0",
                               bus.if_ack, bus.if_rdata, bus.mem_re, bus.stall_if);
        end
        bus.if_req = 0;
        step();
        checks++;
        if (bus.if_ack !== 1'b0 || bus.if_rdata !== 32'hDEADBEEF) begin
            errors++; $display("FAIL fetch_pulse: ack %b rdata %h want 0 deadbeef", bus.if_ack, bus.if_rdata);
        end
    endtask

    task automatic test_priority();
        int we_cnt = 0;
        int dack_c = -1;
        int iack_c = -1;
        bit stall_ok = 1;
        logic [11:0] we_addr = 12'hFFF;
        bus.if_req = 1; bus.if_addr = 32'h14;
        bus.d_req = 1; bus.d_we = 1; bus.d_addr = 32'h20; bus.d_wdata = 32'h5;
        for (int c = 1; c <= 12; c++) begin
            step();
            if (bus.mem_we) begin we_cnt++; we_addr = bus.mem_addr; end
            if (bus.d_ack) begin dack_c = c; bus.d_req = 0; bus.d_we = 0; end
            if (bus.if_ack) begin iack_c = c; bus.if_req = 0; break; end
            else if (!bus.stall_if) stall_ok = 0;
        end
        checks++;
        if (we_cnt != 1 || we_addr !== 12'h020) begin
            errors++; $display("FAIL prio_write: pulses %0d addr %h want 1 020", we_cnt, we_addr);
        end
        checks++;
        if (dack_c != 3 || iack_c != 6) begin
            errors++; $display("FAIL prio_order: d_ack@%0d if_ack@%0d want 3 6", dack_c, iack_c);
        end
        checks++;
        if (!stall_ok) begin
            errors++; $display("FAIL prio_stall_if: dropped %0d want 1 until if_ack", stall_ok);
        end
        step();
    endtask

    task automatic test_starve();
        int  dcnt = 0;
        bit  got_i = 0;
        bus.if_req = 1; bus.if_addr = 32'h80;
        bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h40; bus.mem_rdata = 32'h1234;
        for (int c = 0; c < 80; c++) begin
            step();
            if (bus.d_ack) begin
                dcnt++;
                if (dcnt == 4) begin
                    checks++;
                    if (dut.starve_q !== 4'd4) begin
                        errors++; $display("FAIL starve_peak: got %0d want 4", dut.starve_q);
                    end
                end
            end
            if (bus.if_ack) begin got_i = 1; bus.if_req = 0; bus.d_req = 0; break; end
        end
        checks++;
        if (!got_i) begin
            errors++; $display("FAIL starve_timeout: if_ack seen %0d want 1", got_i);
        end
        checks++;
        if (dcnt != 4) begin
            errors++; $display("FAIL starve_grants: data grants %0d want 4", dcnt);
        end
        checks++;
        if (dut.starve_q !== 4'd0) begin
            errors++; $display("FAIL starve_clear: got %0d want 0", dut.starve_q);
        end
        bus.if_req = 0; bus.d_req = 0;
        step();
    endtask

    task automatic test_lat1();
        bus1.if_req = 1; bus1.if_addr = 32'h4; bus1.mem_rdata = 32'h11;
        step();
        checks++;
        if (bus1.mem_re !== 1'b1 || bus1.mem_addr !== 12'h004 || bus1.if_ack !== 1'b0) begin
            errors++; $display("FAIL lat1_f_c1: re %b addr %h ack %b want 1 004 0", bus1.mem_re, bus1.mem_addr, bus1.if_ack);
        end
        step();
        checks++;
        if (bus1.if_ack !== 1'b1 || bus1.if_rdata !== 32'h11 || bus1.mem_re !== 1'b0) begin
            errors++; $display("FAIL lat1_f_ack: ack %b rdata %h re %b want 1 11 0", bus1.if_ack, bus1.if_rdata, bus1.mem_re);
        end
        bus1.if_req = 0; bus1.d_req = 1; bus1.d_we = 0; bus1.d_addr = 32'h8; bus1.mem_rdata = 32'h22;
        step();
        checks++;
        if (bus1.mem_re !== 1'b1 || bus1.mem_addr !== 12'h008 || bus1.d_ack !== 1'b0) begin
            errors++; $display("FAIL lat1_d_c1: re %b addr %h ack %b want 1 008 0", bus1.mem_re, bus1.mem_addr, bus1.d_ack);
        end
        step();
        checks++;
        if (bus1.d_ack !== 1'b1 || bus1.d_rdata !== 32'h22) begin
            errors++; $display("FAIL lat1_d_ack: ack %b rdata %h want 1 22", bus1.d_ack, bus1.d_rdata);
        end
        bus1.d_req = 0; bus1.if_req = 1; bus1.if_addr = 32'h14; bus1.mem_rdata = 32'h55;
        step();
        step();
        checks++;
        if (bus1.if_ack !== 1'b1 || bus1.if_rdata !== 32'h55) begin
            errors++; $display("FAIL lat1_f2_ack: ack %b rdata %h want 1 55", bus1.if_ack, bus1.if_rdata);
        end
        bus1.if_req = 0; bus1.d_req = 1; bus1.d_we = 1; bus1.d_addr = 32'hC;
        bus1.d_wdata = 32'h33; bus1.mem_rdata = 32'h99;
        step();
        checks++;
        if (bus1.mem_we !== 1'b1 || bus1.mem_re !== 1'b0 || bus1.mem_addr !== 12'h00C || bus1.mem_wdata !== 32'h33) begin
            errors++; $display("FAIL lat1_w_c1: we %b re %b addr %h wdata %h want 1 0 00c 33",
                               bus1.mem_we, bus1.mem_re, bus1.mem_addr, bus1.mem_wdata);
        end
        step();
        checks++;
        if (bus1.d_ack !== 1'b1 || bus1.d_rdata !== 32'h22 || bus1.mem_we !== 1'b0) begin
            errors++; $display("FAIL lat1_w_ack: ack %b rdata %h we %b want 1 22 0", bus1.d_ack, bus1.d_rdata, bus1.mem_we);
        end
        bus1.d_req = 0; bus1.d_we = 0;
        step();
    endtask

    task automatic test_reset_mid();
        bit bad = 0;
        bus.d_req = 1; bus.d_we = 1; bus.d_addr = 32'h30; bus.d_wdata = 32'h77;
        step();
        checks++;
        if (bus.mem_we !== 1'b0 || bus.mem_addr !== 12'h030) begin
            errors++; $display("FAIL rmid_c1: we %b addr %h want 0 030", bus.mem_we, bus.mem_addr);
        end
        @(posedge Clk);
        Rst = 1;
        #1;
        checks++;
        if ({bus.if_ack, bus.d_ack, bus.mem_re, bus.mem_we} !== 4'b0 ||
            {bus.if_rdata, bus.d_rdata, bus.mem_wdata, bus.mem_addr} !== 108'h0) begin
            errors++; $display("FAIL rmid_zero: ctrl %b data %h want 0 0",
                               {bus.if_ack, bus.d_ack, bus.mem_re, bus.mem_we},
                               {bus.if_rdata, bus.d_rdata, bus.mem_wdata, bus.mem_addr});
        end
        for (int c = 0; c < 2; c++) begin
            step();
            if (bus.mem_we !== 1'b0 || bus.d_ack !== 1'b0) bad = 1;
        end
        Rst = 0;
        #1;
        if (bus.mem_we !== 1'b0 || bus.d_ack !== 1'b0) bad = 1;
        checks++;
        if (bad) begin
            errors++; $display("FAIL rmid_quiet: we/ack seen %0d want 0", bad);
        end
        step();
        checks++;
        if (bus.mem_addr !== 12'h030 || bus.mem_wdata !== 32'h77 || bus.mem_we !== 1'b0 || bus.d_ack !== 1'b0) begin
            errors++; $display("FAIL rmid_regrant: addr %h wdata %h we %b ack %b want 030 77 0 0",
                               bus.mem_addr, bus.mem_wdata, bus.mem_we, bus.d_ack);
        end
        step();
        checks++;
        if (bus.mem_we !== 1'b1) begin
            errors++; $display("FAIL rmid_write: we %b want 1", bus.mem_we);
        end
        step();
        checks++;
        if (bus.d_ack !== 1'b1 || bus.mem_we !== 1'b0) begin
            errors++; $display("FAIL rmid_ack: ack %b we %b want 1 0", bus.d_ack, bus.mem_we);
        end
        bus.d_req = 0; bus.d_we = 0;
        step();
    endtask

    task automatic test_addr_stable();
        bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h44; bus.mem_rdata = 32'hABCD;
        step();
        bus.d_addr = 32'hF00; bus.d_we = 1; bus.d_wdata = 32'h1;
        step();
        checks++;
        if (bus.mem_addr !== 12'h044 || bus.mem_re !== 1'b1 || bus.mem_we !== 1'b0) begin
            errors++; $display("FAIL stable_addr: addr %h re %b we %b want 044 1 0", bus.mem_addr, bus.mem_re, bus.mem_we);
        end
        step();
        checks++;
        if (bus.d_ack !== 1'b1 || bus.d_rdata !== 32'hABCD) begin
            errors++; $display("FAIL stable_ack: ack %b rdata %h want 1 abcd", bus.d_ack, bus.d_rdata);
        end
        bus.d_req = 0; bus.d_we = 0;
        step();
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_priority();
        test_starve();
        test_lat1();
        test_reset_mid();
        test_addr_stable();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter MEM_LAT, default 2, memory access latency in cycles; legal range 1..7.
REQ-002 Parameter STARVE_MAX, default 4, number of consecutive lost arbitrations after which fetch wins; legal range 1..15.
REQ-003 Ports:
- Clk  in  1  sole clock; all state updates on rising edge.
- Rst  in  1  asynchronous, active-high reset.
- if_req  in  1  fetch-stage read request.
- if_addr  in  32  fetch byte address.
- if_ack  out  1  one-cycle pulse; if_rdata valid.
- if_rdata  out  32  registered fetch read data.
- d_req  in  1  MEM-stage access request.
- d_we  in  1  1 = write, 0 = read.
- d_addr  in  32  data byte address.
- d_wdata  in  32  write data.
- d_ack  out  1  one-cycle completion pulse.
- d_rdata  out  32  registered data read data.
- mem_addr  out  12  shared memory byte address, bits [11:0].
- mem_wdata  out  32  shared memory write data.
- mem_re  out  1  shared memory read enable.
- mem_we  out  1  shared memory write enable.
- mem_rdata  in  32  shared memory read data.
- stall_if  out  1  freeze PC and IF/ID.
- stall_mem  out  1  freeze EX/MEM and earlier stages.

Function
REQ-004 The FSM SHALL have exactly three states: IDLE, IACC (fetch access) and DACC (data access).
REQ-005 In IDLE with d_req=1, the FSM SHALL go to DACC unless the starvation rule (REQ-007) applies.
REQ-006 In IDLE with only if_req=1, the FSM SHALL go to IACC; with no request it SHALL stay in IDLE.
REQ-007 starve_cnt SHALL increment when both requests are pending in IDLE and data is granted; if starve_cnt equals STARVE_MAX, fetch SHALL be granted instead.
REQ-008 starve_cnt SHALL clear on any fetch grant.
REQ-009 On grant, the block SHALL latch addr[11:0], d_we and d_wdata into internal registers.
REQ-010 mem_addr, mem_wdata and the latched write flag SHALL stay stable for the whole access, independent of later input changes.
REQ-011 On grant, a latency counter SHALL load MEM_LAT-1 and decrement each cycle in IACC/DACC; the final access cycle is the one with count 0.
REQ-012 mem_re SHALL be 1 throughout IACC and throughout DACC reads.
REQ-013 mem_we SHALL be 1 only in the final cycle of a DACC write, giving exactly one write per access.
REQ-014 In the final cycle, mem_rdata SHALL be captured into if_rdata (IACC) or d_rdata (DACC read).
REQ-015 In the final cycle, the FSM SHALL return to IDLE, and the matching ack SHALL be 1 in the following cycle for exactly one cycle.
REQ-016 d_rdata SHALL be left unchanged on writes.
REQ-017 An access SHALL take MEM_LAT+1 cycles from grant to ack; back-to-back accesses SHALL be separated by the one IDLE cycle in which ack is high.
REQ-018 In the IDLE cycle where a requester's ack is 1, that requester's req SHALL be ignored for arbitration.
REQ-019 The other requester MAY be granted in that same IDLE cycle.
REQ-020 stall_if SHALL equal if_req & ~if_ack, and stall_mem SHALL equal d_req & ~d_ack, both combinational.
REQ-021 A requester SHALL hold req, addr and data stable until its ack.
REQ-022 Deassertion of req during an access SHALL NOT abort the access; the ack SHALL still be issued.
REQ-023 When MEM_LAT=1, the grant cycle SHALL also be the final cycle.

Reset
REQ-024 While Rst=1, the FSM SHALL be in IDLE and starve_cnt and the latency counter SHALL be 0.
REQ-025 While Rst=1, if_ack, d_ack, mem_re and mem_we SHALL be 0, and if_rdata, d_rdata, mem_addr and mem_wdata SHALL be 32'h0/12'h0, all immediately and without waiting for Clk.
REQ-026 Reset asserted mid-access SHALL abort the access with no ack and no mem_we pulse; arbitration SHALL restart from IDLE on the first edge after Rst falls.

Verification
REQ-027 The bench SHALL cover these directed scenarios:
- MEM_LAT=2, if_req=1, if_addr=32'h10, mem_rdata=32'hDEADBEEF -> mem_re high 2 cycles, mem_addr=12'h010, if_ack one pulse on 3rd cycle after grant, if_rdata=32'hDEADBEEF.
- if_req and d_req both raised in the same cycle, d_we=1, d_addr=32'h20, d_wdata=32'h5 -> DACC first with a single mem_we pulse at mem_addr=12'h020; stall_if stays high until if_ack follows.
- STARVE_MAX=4, d_req held high with back-to-back requests, if_req=1 -> exactly 4 data grants, then one fetch grant, then starve_cnt=0.
- MEM_LAT=1, alternating single requests -> each access takes 2 cycles (grant plus ack/IDLE cycle).
- Rst pulsed in the 2nd cycle of a DACC write -> mem_we never asserted, no d_ack, all outputs 0 during Rst; fresh grant on the first edge after release.
- d_addr changed mid-access -> mem_addr keeps the latched value.
